// File: rtl/delay_scheduler.sv
// Round-robin owner of one shared delay timer: grant, then mid_pulse, then per-requester done. Grant is seen 1 cycle after req is sampled.
// done follows grant by offset+1 cycles. req is ignored while busy. DELAY_SCHED_PRIO0_EN gives req[0] fixed priority.
module delay_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 30
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   delay_in,
  input  logic                       abort,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         done,
  output logic                       mid_pulse,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] owner
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               mid_q, mid_d;
  logic               busy_q, busy_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]   offset_q, offset_d;
  logic [WIDTH-1:0]   count_q, count_d;

  logic [NUM_REQ-1:0] req_rr;
  logic [IDX_W-1:0]   cand;
  logic               rr_hit;
  logic [IDX_W-1:0]   rr_idx;
  logic               arb_vld;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_upd;
  logic [WIDTH-1:0]   arb_delay;

  // Scan starts just after the last round-robin winner and wraps.
  always_comb begin
`ifdef DELAY_SCHED_PRIO0_EN
    req_rr = {req[NUM_REQ-1:1], 1'b0};
`else
    req_rr = req;
`endif
    rr_hit = 1'b0;
    rr_idx = '0;
    cand   = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == LAST_IDX) ? '0 : cand + IDX_W'(1);
      if (!rr_hit && req_rr[cand]) begin
        rr_hit = 1'b1;
        rr_idx = cand;
      end
    end
`ifdef DELAY_SCHED_PRIO0_EN
    arb_vld = req[0] | rr_hit;
    arb_idx = req[0] ? '0 : rr_idx;
    arb_upd = !req[0];
`else
    arb_vld = rr_hit;
    arb_idx = rr_idx;
    arb_upd = 1'b1;
`endif
  end

  always_comb begin
    arb_delay = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == IDX_W'(i)) arb_delay = delay_in[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = '0;
    done_d   = '0;
    mid_d    = 1'b0;
    busy_d   = busy_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    offset_d = offset_q;
    count_d  = count_q;
    unique case (state_q)
      IDLE: begin
        if (arb_vld) begin
          owner_d          = arb_idx;
          offset_d         = arb_delay;
          count_d          = '0;
          grant_d[arb_idx] = 1'b1;
          busy_d           = 1'b1;
          state_d          = RUN;
          if (arb_upd) rr_ptr_d = arb_idx;
        end
      end
      RUN: begin
        // Completion is checked before abort and before any increment, so a maximal offset never wraps.
        if (count_q == offset_q) begin
          done_d[owner_q] = 1'b1;
          mid_d           = (count_q == (offset_q >> 1));
          busy_d          = 1'b0;
          state_d         = IDLE;
        end else if (abort) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          count_d = count_q + WIDTH'(1);
          mid_d   = (count_q == (offset_q >> 1));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      done_q   <= '0;
      mid_q    <= 1'b0;
      busy_q   <= 1'b0;
      owner_q  <= '0;
      rr_ptr_q <= LAST_IDX;
      offset_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      mid_q    <= mid_d;
      busy_q   <= busy_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      offset_q <= offset_d;
      count_q  <= count_d;
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign mid_pulse = mid_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_delay_scheduler.sv
// Scoreboarded bench for delay_scheduler: stimulus queues expected grant/mid/done/busy-edge events, a negedge monitor pops and compares.
module tb_delay_scheduler;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 30;
  localparam int IDX_W   = 2;
  localparam int K_GRANT = 0;
  localparam int K_MID   = 1;
  localparam int K_DONE  = 2;
  localparam int K_BUP   = 3;
  localparam int K_BDN   = 4;

  typedef struct {
    int cyc;
    int kind;
    int val;
    int own;
  } ev_t;

  ev_t exp_q[$];

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] delay_in;
  logic                     abort;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       done;
  logic                     mid_pulse;
  logic                     busy;
  logic [IDX_W-1:0]         owner;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;
  logic busy_prev = 1'b0;

  delay_scheduler #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .req(req), .delay_in(delay_in), .abort(abort),
    .grant(grant), .done(done), .mid_pulse(mid_pulse), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic see(input int kind, input int val);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event cyc=%0d kind=%0d val=%0h (required: no event)", cyc, kind, val);
    end else begin
      e = exp_q.pop_front();
      if (e.cyc != cyc || e.kind != kind || e.val != val || (kind == K_GRANT && e.own != int'(owner))) begin
        failures++;
        $display("FAIL event got cyc=%0d kind=%0d val=%0h owner=%0d required cyc=%0d kind=%0d val=%0h owner=%0d",
                 cyc, kind, val, owner, e.cyc, e.kind, e.val, e.own);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (grant != '0) see(K_GRANT, int'(grant));
      if (mid_pulse) see(K_MID, 1);
      if (done != '0) see(K_DONE, int'(done));
      if (busy && !busy_prev) see(K_BUP, 1);
      if (!busy && busy_prev) see(K_BDN, 1);
    end
    busy_prev = busy;
  end

  task automatic push_ev(input int c, input int k, input int v, input int o);
    ev_t e;
    e.cyc = c; e.kind = k; e.val = v; e.own = o;
    exp_q.push_back(e);
  endtask

  task automatic push_xfer(input int g, input int idx, input int off);
    push_ev(g, K_GRANT, 1 << idx, idx);
    push_ev(g, K_BUP, 1, 0);
    push_ev(g + off / 2 + 1, K_MID, 1, 0);
    push_ev(g + off + 1, K_DONE, 1 << idx, 0);
    push_ev(g + off + 1, K_BDN, 1, 0);
  endtask

  task automatic set_delay(input int i, input int v);
    delay_in[i*WIDTH +: WIDTH] = WIDTH'(v);
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic chk_idle(input string name);
    checks++;
    if (grant !== '0 || done !== '0 || mid_pulse !== 1'b0 || busy !== 1'b0 || owner !== '0) begin
      failures++;
      $display("FAIL %s got grant=%b done=%b mid=%b busy=%b owner=%0d required all zero",
               name, grant, done, mid_pulse, busy, owner);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int g2;
    rst = 1'b1; req = '0; delay_in = '0; abort = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk_idle("reset_state");

    // Single request, delay 4
    set_delay(0, 4); req = 4'b0001; g = cyc + 1;
    push_xfer(g, 0, 4);
    wait_to(g); req = '0;
    wait_to(g + 7);

    // Round robin from reset, all delays 1
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_delay(i, 1);
    req = 4'b1111; g = cyc + 1;
    for (int k = 0; k < 5; k++) push_xfer(g + 3 * k, k % 4, 1);
    wait_to(g + 12); req = '0;
    wait_to(g + 16);

    // Zero delay
    set_delay(2, 0); req = 4'b0100; g = cyc + 1;
    push_xfer(g, 2, 0);
    wait_to(g); req = '0;
    wait_to(g + 3);

    // Abort at count 2 with req[2] pending
    set_delay(1, 10); set_delay(2, 3); req = 4'b0010; g = cyc + 1;
    push_ev(g, K_GRANT, 2, 1);
    push_ev(g, K_BUP, 1, 0);
    push_ev(g + 3, K_BDN, 1, 0);
    push_xfer(g + 4, 2, 3);
    wait_to(g); req = 4'b0100;
    wait_to(g + 2); abort = 1'b1;
    wait_to(g + 3); abort = 1'b0;
    wait_to(g + 4); req = '0;
    wait_to(g + 9);

    // Abort ignored in IDLE; abort coincident with count==offset completes
    abort = 1'b1; req = 4'b0010; g = cyc + 1;
    push_xfer(g, 1, 10);
    wait_to(g); req = '0; abort = 1'b0;
    wait_to(g + 10); abort = 1'b1;
    wait_to(g + 11); abort = 1'b0;
    wait_to(g + 13);

    // Reset at count 5 of delay 8, then req[0] wins over req[1]
    set_delay(2, 8); req = 4'b0100; g = cyc + 1;
    push_ev(g, K_GRANT, 4, 2);
    push_ev(g, K_BUP, 1, 0);
    push_ev(g + 5, K_MID, 1, 0);
    push_ev(g + 6, K_BDN, 1, 0);
    wait_to(g); req = '0;
    wait_to(g + 5); rst = 1'b1;
    wait_to(g + 6);
    chk_idle("reset_midrun");
    rst = 1'b0;
    set_delay(0, 2); set_delay(1, 2); req = 4'b0011; g2 = cyc + 1;
    push_xfer(g2, 0, 2);
    push_xfer(g2 + 4, 1, 2);
    wait_to(g2); req = 4'b0010;
    wait_to(g2 + 4); req = '0;
    wait_to(g2 + 8);

`ifdef DELAY_SCHED_PRIO0_EN
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_delay(i, 1);
    req = 4'b0111; g = cyc + 1;
    push_xfer(g, 0, 1);
    push_xfer(g + 3, 1, 1);
    push_xfer(g + 6, 0, 1);
    push_xfer(g + 9, 2, 1);
    push_xfer(g + 12, 0, 1);
    wait_to(g);      req[0] = 1'b0;
    wait_to(g + 3);  req[0] = 1'b1;
    wait_to(g + 6);  req[0] = 1'b0;
    wait_to(g + 9);  req[0] = 1'b1;
    wait_to(g + 12); req = '0;
    wait_to(g + 16);
`endif

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_events got %0d outstanding required 0 (next cyc=%0d kind=%0d)",
               exp_q.size(), exp_q[0].cyc, exp_q[0].kind);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
